// File: rtl/fifo_write_arbiter.sv
// Purpose : round-robin arbiter sharing one dual-clock FIFO write port between NUM_REQ requesters.
// Latency : 1 cycle from accept (reqValid & reqReady) to fifoWriteEnable/fifoDataIn.
// Backpr. : reqReady drops in the same cycle the FIFO credit check fails; nothing is latched while stalled.
//
// Ports:
//   inClk, aresetnIn      write-side clock, asynchronous active-low reset
//   reqValid/reqData      per-requester valid and payload (requester i at [i*WIDTH +: WIDTH])
//   reqReady              one-hot combinational accept toward the winning requester
//   fifoWriteEnable       registered write strobe, fifoDataIn = {id, payload}
//   fifoWrusedw           FIFO write-side fill level, lags our writes by WRUSEDW_LAT cycles
//   running               high once the post-reset hold has expired
//   acceptCount           free-running count of accepted words, wraps at 2^32
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 60,
    parameter int ID_W        = 2,
    parameter int DEPTH_LOG2  = 5,
    parameter int WRUSEDW_LAT = 4,   // must be >= 2
    parameter int MARGIN      = 2,
    parameter int HOLD_CYCLES = 8    // must be >= 1
) (
    input  logic                     inClk,
    input  logic                     aresetnIn,
    input  logic [NUM_REQ-1:0]       reqValid,
    input  logic [NUM_REQ*WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]       reqReady,
    output logic                     fifoWriteEnable,
    output logic [WIDTH+ID_W-1:0]    fifoDataIn,
    input  logic [DEPTH_LOG2-1:0]    fifoWrusedw,
    output logic                     running,
    output logic [31:0]              acceptCount
);

    localparam int SUM_W  = DEPTH_LOG2 + 2;
    localparam int HIST_W = WRUSEDW_LAT - 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [SUM_W-1:0] LIMIT = SUM_W'((1 << DEPTH_LOG2) - 1 - MARGIN);

    typedef enum logic {HOLD, RUN} state_t;

    state_t            state;
    logic [HOLD_W-1:0] holdCnt;
    logic [ID_W-1:0]   rrPtr;
    logic [HIST_W-1:0] wrHist;

    logic [SUM_W-1:0]  inflight;
    logic [SUM_W-1:0]  usedSum;
    logic              canWrite;
    logic              found;
    logic [ID_W-1:0]   winner;
    logic              accept;
    logic [WIDTH-1:0]  winPayload;

    // Writes not yet visible in fifoWrusedw: the strobe currently on the
    // port plus the previous WRUSEDW_LAT-1 strobes. Together these form the
    // WRUSEDW_LAT-cycle window before a write shows up in the fill level.
    always_comb begin
        inflight = SUM_W'(fifoWriteEnable);
        for (int k = 0; k < HIST_W; k++) begin
            inflight = inflight + SUM_W'(wrHist[k]);
        end
    end

    assign usedSum  = SUM_W'(fifoWrusedw) + inflight + SUM_W'(1);
    assign canWrite = (state == RUN) && (usedSum <= LIMIT);

    // Round-robin search: first valid requester at or after rrPtr, wrapping.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!found && reqValid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign accept     = found && canWrite;
    assign winPayload = reqData[int'(winner)*WIDTH +: WIDTH];

    always_comb begin
        reqReady = '0;
        if (accept) begin
            reqReady[winner] = 1'b1;
        end
    end

    assign running = (state == RUN);

    always_ff @(posedge inClk or negedge aresetnIn) begin
        if (!aresetnIn) begin
            state           <= HOLD;
            holdCnt         <= HOLD_W'(HOLD_CYCLES);
            rrPtr           <= '0;
            wrHist          <= '0;
            fifoWriteEnable <= 1'b0;
            fifoDataIn      <= '0;
            acceptCount     <= '0;
        end else begin
            // Hold off writes until the FIFO's own clear has propagated.
            if (state == HOLD) begin
                holdCnt <= holdCnt - HOLD_W'(1);
                if (holdCnt == HOLD_W'(1)) begin
                    state <= RUN;
                end
            end

            wrHist          <= (wrHist << 1) | HIST_W'(fifoWriteEnable);
            fifoWriteEnable <= accept;

            if (accept) begin
                rrPtr       <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                fifoDataIn  <= {winner, winPayload};
                acceptCount <= acceptCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Purpose : scoreboard bench for fifo_write_arbiter with a lagging-wrusedw FIFO model.
// Latency : expected words queued at stimulus time, popped when fifoWriteEnable is seen.
// Backpr. : FIFO model never drains unless the stimulus lowers its offset.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 60;
    localparam int ID_W    = 2;
    localparam int LIMIT   = 29;

    logic                     inClk;
    logic                     aresetnIn;
    logic [NUM_REQ-1:0]       reqValid;
    logic [NUM_REQ*WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]       reqReady;
    logic                     fifoWriteEnable;
    logic [WIDTH+ID_W-1:0]    fifoDataIn;
    logic [4:0]               fifoWrusedw;
    logic                     running;
    logic [31:0]              acceptCount;

    fifo_write_arbiter dut (
        .inClk           (inClk),
        .aresetnIn       (aresetnIn),
        .reqValid        (reqValid),
        .reqData         (reqData),
        .reqReady        (reqReady),
        .fifoWriteEnable (fifoWriteEnable),
        .fifoDataIn      (fifoDataIn),
        .fifoWrusedw     (fifoWrusedw),
        .running         (running),
        .acceptCount     (acceptCount)
    );

    initial begin
        inClk = 1'b0;
        forever #5 inClk = ~inClk;
    end

    // FIFO fill-level model: a write strobed in cycle t appears in wrusedw at t+4.
    logic [2:0] dl;
    int         seen = 0;
    int         seenBase = 0;
    int         usedOffset = 0;

    always_ff @(posedge inClk or negedge aresetnIn) begin
        if (!aresetnIn) dl <= '0;
        else            dl <= {dl[1:0], fifoWriteEnable};
    end

    always_ff @(posedge inClk) begin
        if (dl[2]) seen <= seen + 1;
    end

    always_comb fifoWrusedw = 5'(usedOffset + seen - seenBase);

    logic [WIDTH+ID_W-1:0] expQ[$];
    logic [WIDTH+ID_W-1:0] expW;
    int nCmp = 0;
    int nBad = 0;
    int wrTotal = 0;
    int wrBase = 0;
    logic [7:0] tag;

    function automatic logic [WIDTH-1:0] pay(input logic [7:0] t, input int i);
        return {t, 48'h5A5A_0F0F_C3C3, 4'(i)};
    endfunction

    function automatic logic [WIDTH+ID_W-1:0] word(input logic [7:0] t, input int i);
        return {ID_W'(i), pay(t, i)};
    endfunction

    task automatic setData(input logic [7:0] t);
        for (int i = 0; i < NUM_REQ; i++) reqData[i*WIDTH +: WIDTH] = pay(t, i);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic waitDrain(input string nm);
        for (int k = 0; k < 40 && expQ.size() != 0; k++) @(negedge inClk);
        nCmp++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("FAIL %s pending_words=%0d required=0", nm, expQ.size());
        end
    endtask

    initial begin
        aresetnIn = 1'b0;
        reqValid  = '0;
        reqData   = '0;
        tag       = 8'h11;

        // Monitor: pops expected words whenever the DUT strobes a write.
        fork
            forever begin
                @(negedge inClk);
                if (aresetnIn && fifoWriteEnable) begin
                    wrTotal++;
                    nCmp++;
                    if (expQ.size() == 0) begin
                        nBad++;
                        $display("FAIL unexpected_write actual=%0h required=none", fifoDataIn);
                    end else begin
                        expW = expQ.pop_front();
                        if (fifoDataIn !== expW) begin
                            nBad++;
                            $display("FAIL write_word actual=%0h required=%0h", fifoDataIn, expW);
                        end
                    end
                    nCmp++;
                    if (usedOffset + wrTotal - wrBase > LIMIT) begin
                        nBad++;
                        $display("FAIL occupancy actual=%0d required<=%0d",
                                 usedOffset + wrTotal - wrBase, LIMIT);
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge inClk);
        #1;
        chk("rst_reqReady", 64'(reqReady), 64'h0);
        chk("rst_wrEn", 64'(fifoWriteEnable), 64'h0);
        chk("rst_dataIn", 64'(fifoDataIn), 64'h0);
        chk("rst_running", 64'(running), 64'h0);
        chk("rst_acceptCount", 64'(acceptCount), 64'h0);

        // Hold period then round-robin over all four requesters
        setData(tag);
        reqValid = 4'b1111;
        for (int k = 0; k < 6; k++) expQ.push_back(word(tag, k % 4));
        aresetnIn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("hold_reqReady", 64'(reqReady), 64'h0);
            @(negedge inClk);
        end
        #1;
        chk("run_first_reqReady", 64'(reqReady), 64'h1);
        chk("run_running", 64'(running), 64'h1);
        repeat (6) @(negedge inClk);

        // Only requesters 1 and 3, rrPtr = 2: grants 3,1,3
        tag = 8'h22;
        setData(tag);
        reqValid = 4'b1010;
        expQ.push_back(word(tag, 3));
        expQ.push_back(word(tag, 1));
        expQ.push_back(word(tag, 3));
        #1;
        chk("rr6_acceptCount", 64'(acceptCount), 64'd6);
        chk("sparse_grant3", 64'(reqReady), 64'h8);
        @(negedge inClk);
        #1;
        chk("sparse_grant1", 64'(reqReady), 64'h2);
        repeat (2) @(negedge inClk);
        reqValid = '0;
        #1;
        chk("sparse_acceptCount", 64'(acceptCount), 64'd9);
        waitDrain("drain_sparse");
        repeat (6) @(negedge inClk);

        // Credit limit: wrusedw=26 admits exactly three writes
        tag = 8'h33;
        setData(tag);
        seenBase   = seen;
        wrBase     = wrTotal;
        usedOffset = 26;
        reqValid   = 4'b1111;
        for (int k = 0; k < 3; k++) expQ.push_back(word(tag, k));
        #1;
        chk("credit_first", 64'(reqReady), 64'h1);
        repeat (3) @(negedge inClk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("credit_blocked", 64'(reqReady), 64'h0);
            @(negedge inClk);
        end
        usedOffset = 23;
        for (int k = 3; k < 6; k++) expQ.push_back(word(tag, k % 4));
        #1;
        chk("credit_reopen", 64'(reqReady), 64'h8);
        repeat (3) @(negedge inClk);
        #1;
        chk("credit_reblocked", 64'(reqReady), 64'h0);
        chk("credit_acceptCount", 64'(acceptCount), 64'd15);
        reqValid = '0;
        waitDrain("drain_credit");
        repeat (6) @(negedge inClk);

        // Non-draining FIFO with all requesters streaming: exactly LIMIT words
        tag = 8'h55;
        setData(tag);
        seenBase   = seen;
        wrBase     = wrTotal;
        usedOffset = 0;
        reqValid   = 4'b1111;
        for (int k = 0; k < LIMIT; k++) expQ.push_back(word(tag, (k + 2) % 4));
        #1;
        chk("fill_first", 64'(reqReady), 64'h4);
        repeat (40) @(negedge inClk);
        #1;
        chk("fill_blocked", 64'(reqReady), 64'h0);
        chk("fill_acceptCount", 64'(acceptCount), 64'd44);
        reqValid = '0;
        waitDrain("drain_fill");

        // Reset mid-stream
        tag = 8'h66;
        setData(tag);
        seenBase   = seen;
        wrBase     = wrTotal;
        usedOffset = 0;
        reqValid   = 4'b1111;
        expQ.push_back(word(tag, 3));
        expQ.push_back(word(tag, 0));
        #1;
        chk("pre_reset_grant", 64'(reqReady), 64'h8);
        repeat (2) @(negedge inClk);
        #2;
        aresetnIn = 1'b0;
        #1;
        chk("midrst_wrEn", 64'(fifoWriteEnable), 64'h0);
        chk("midrst_acceptCount", 64'(acceptCount), 64'h0);
        chk("midrst_running", 64'(running), 64'h0);
        chk("midrst_reqReady", 64'(reqReady), 64'h0);
        chk("midrst_pending", 64'(expQ.size()), 64'h0);
        repeat (2) @(negedge inClk);
        aresetnIn  = 1'b1;
        seenBase   = seen;
        wrBase     = wrTotal;
        tag        = 8'h77;
        setData(tag);
        expQ.push_back(word(tag, 0));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rehold_reqReady", 64'(reqReady), 64'h0);
            @(negedge inClk);
        end
        #1;
        chk("rehold_first_grant", 64'(reqReady), 64'h1);
        @(negedge inClk);
        reqValid = '0;
        #1;
        chk("rehold_acceptCount", 64'(acceptCount), 64'd1);
        waitDrain("drain_rehold");
        repeat (4) @(negedge inClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one dualClockFIFO between NUM_REQ requesters in the inClk domain.
- Round-robin grants, one accepted word per cycle, tagged with the source index.
- Throttles writes from the stale wrusedw plus a count of in-flight writes, so the FIFO never overflows with overflow checking off.
- Holds all writes after reset until the FIFO's clear has propagated.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 60, payload bits per requester
ID_W, 2, source-tag width, clog2(NUM_REQ)
DEPTH_LOG2, 5, FIFO depth log2, matches the attached FIFO
WRUSEDW_LAT, 4, cycles between a write issued here and its appearance in fifoWrusedw
MARGIN, 2, slots kept free below the FIFO full level
HOLD_CYCLES, 8, post-reset cycles with writes blocked

Ports:
inClk  in  1  write-side clock
aresetnIn  in  1  reset, asynchronous, active-low
reqValid  in  NUM_REQ  per-requester data valid
reqData  in  NUM_REQ*WIDTH  payloads; requester i at bits [i*WIDTH +: WIDTH]
reqReady  out  NUM_REQ  one-hot accept, combinational
fifoWriteEnable  out  1  registered write strobe to FIFO
fifoDataIn  out  WIDTH+ID_W  registered {id, payload}
fifoWrusedw  in  DEPTH_LOG2  FIFO wrusedw
running  out  1  state==RUN
acceptCount  out  32  total words accepted, wraps

Behaviour:
- Reset (aresetnIn low, asynchronous):
  - state=HOLD, holdCnt=HOLD_CYCLES, rrPtr=0.
  - fifoWriteEnable=0, fifoDataIn=0, reqReady=0, running=0, acceptCount=0, inflight shift register cleared.
- FSM:
  - HOLD: holdCnt decrements each cycle. HOLD->RUN on the cycle holdCnt==1, so RUN is entered exactly HOLD_CYCLES cycles after reset release.
  - RUN: terminal. Only reset leaves it; a reset mid-RUN drops back to HOLD immediately and any in-flight accept is discarded.
- Credit check:
  - inflight = popcount of a WRUSEDW_LAT-deep shift register fed by fifoWriteEnable.
  - canWrite = RUN && (fifoWrusedw + inflight + 1) <= LIMIT, where LIMIT = 2^DEPTH_LOG2 - 1 - MARGIN.
  - Sum evaluated in DEPTH_LOG2+2 bits; no wrap permitted.
- Arbitration:
  - Search reqValid starting at rrPtr, ascending, wrapping modulo NUM_REQ. The first set bit i is the winner.
  - reqReady[i]=canWrite for the winner; all other bits are 0.
  - Accept = reqValid[i]&&reqReady[i].
  - On accept: rrPtr<=(i+1) mod NUM_REQ. Without accept, rrPtr holds.
- Output latency 1:
  - On accept: fifoWriteEnable<=1, fifoDataIn<={i[ID_W-1:0], payload_i}, acceptCount<=acceptCount+1.
  - Otherwise fifoWriteEnable<=0 and fifoDataIn holds its previous value.
- Boundary conditions:
  - At most one accept per cycle.
  - A requester that drops valid before accept loses nothing; no grant is latched.
  - With all requesters continuously valid, grants rotate 0,1,2,3,0...
  - When canWrite falls, reqReady is 0 in that same cycle.
  - Occupancy never exceeds LIMIT+WRUSEDW_LAT-inflight-aware bound, i.e. never reaches 2^DEPTH_LOG2-1.
  - acceptCount wraps from 2^32-1 to 0.

Test Plan:
- Reset release, all reqValid=1, fifoWrusedw=0 -> reqReady=0 for 8 cycles. First accept goes to requester 0 on cycle 8; fifoWriteEnable=1 on cycle 9 with id=0.
- All four requesters valid, fifoWrusedw=0, backpressure disabled -> ids 0,1,2,3,0,1 on consecutive cycles; acceptCount=6.
- Only requesters 1 and 3 valid, rrPtr=2 -> grant 3, then 1, then 3.
- fifoWrusedw=26, no writes in the last 4 cycles -> three consecutive accepts (27,28,29 ≤ 29), then reqReady=0 until fifoWrusedw drops.
- FIFO model drained at 0 words/cycle with all requesters streaming -> the modelled FIFO never reports wrfull and no word is lost.
- aresetnIn pulsed low mid-stream -> fifoWriteEnable=0 and acceptCount=0 immediately; HOLD lasts 8 cycles again; first post-reset grant goes to requester 0.
